subneg_seq: RTL and testbench

- Instruction sequencer and write-back master for the SUBNEG core; it drives the data memory from the writer side.
- Per instruction it fetches the three words A, B, C from instruction ROM, reads mem[A] and mem[B], and computes mem[B] - mem[A].
- It writes the result back to data memory at address B, then branches to C if the result is negative, otherwise falls through to PC+3.
- Both ROM and data memory are synchronous-read with 1-cycle latency.

---
 rtl/subneg_pkg.sv | 25 ++
 rtl/subneg_seq_if.sv | 39 +++
 rtl/subneg_alu.sv | 23 ++
 rtl/subneg_seq.sv | 131 +++++++++++++
 tb/tb_subneg_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/subneg_pkg.sv
// -----------------------------------------------------------------------------
// subneg_pkg
// Shared definitions for the SUBNEG core: sequencer state encoding, the
// program-counter stride of one instruction, and default word/address widths.
// No ports.
// -----------------------------------------------------------------------------
package subneg_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 8;

    // One instruction occupies three consecutive ROM words: A, B, C.
    localparam int PC_STEP = 3;

    typedef enum logic [2:0] {
        S_IF_A = 3'd0,
        S_IF_B = 3'd1,
        S_IF_C = 3'd2,
        S_RD_A = 3'd3,
        S_RD_B = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

endpackage : subneg_pkg

// File: rtl/subneg_seq_if.sv
// -----------------------------------------------------------------------------
// subneg_seq_if
// Bundles the sequencer's ROM port, data-memory read/write ports and status.
//   run        : level enable into the sequencer
//   rom_addr   : instruction ROM address       rom_data   : ROM word (1-cycle latency)
//   dmem_raddr : data memory read address     dmem_rdata : read data (1-cycle latency)
//   dmem_we    : write strobe                 dmem_waddr / dmem_wdata : write address/data
//   pc         : current instruction address  halt       : halt branch taken
// Modports: master = sequencer, slave = memories / environment.
// -----------------------------------------------------------------------------
interface subneg_seq_if
    import subneg_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              run;
    logic [ADDR_W-1:0] rom_addr;
    logic [WIDTH-1:0]  rom_data;
    logic [ADDR_W-1:0] dmem_raddr;
    logic [WIDTH-1:0]  dmem_rdata;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [WIDTH-1:0]  dmem_wdata;
    logic [ADDR_W-1:0] pc;
    logic              halt;

    modport master (
        input  run, rom_data, dmem_rdata,
        output rom_addr, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, pc, halt
    );

    modport slave (
        output run, rom_data, dmem_rdata,
        input  rom_addr, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, pc, halt
    );

endinterface : subneg_seq_if

// File: rtl/subneg_alu.sv
// -----------------------------------------------------------------------------
// subneg_alu
// Combinational subtract-and-test for SUBNEG: diff = opB - opA (mod 2^WIDTH),
// neg = sign bit of the truncated difference. Signed overflow is deliberately
// not detected; zero is not negative.
//   opa_i  : subtrahend (mem[A])      opb_i : minuend (mem[B])
//   diff_o : difference               neg_o : branch condition
// -----------------------------------------------------------------------------
module subneg_alu
    import subneg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             neg_o
);

    assign diff_o = opb_i - opa_i;
    assign neg_o  = diff_o[WIDTH-1];

endmodule : subneg_alu

// File: rtl/subneg_seq.sv
// -----------------------------------------------------------------------------
// subneg_seq
// Instruction sequencer and write-back master of the SUBNEG core. Each
// instruction takes six cycles: fetch A, B, C from ROM, read mem[A] and
// mem[B], write mem[B]-mem[A] back to B and branch to C when negative
// (C == HALT_ADDR halts), otherwise fall through to pc+3.
//   clk : core clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : subneg_seq_if.master (ROM, data memory, run, pc, halt)
// -----------------------------------------------------------------------------
module subneg_seq
    import subneg_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] HALT_ADDR = '1
) (
    input  logic         clk,
    input  logic         rst,
    subneg_seq_if.master bus
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic [ADDR_W-1:0] c_q;
    logic [WIDTH-1:0]  opa_q;
    logic              halt_q;

    logic [ADDR_W-1:0] rom_word;
    logic [WIDTH-1:0]  diff;
    logic              neg;

    // ROM words are address-sized; only the low ADDR_W bits carry meaning.
    assign rom_word = bus.rom_data[ADDR_W-1:0];

    // opB is taken straight from the memory in S_WB; it is never registered.
    subneg_alu #(.WIDTH(WIDTH)) u_alu (
        .opa_i  (opa_q),
        .opb_i  (bus.dmem_rdata),
        .diff_o (diff),
        .neg_o  (neg)
    );

    // Each state captures the data answering the address issued by the
    // previous state, so the 1-cycle memory latency is hidden by the FSM.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF_A;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            opa_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IF_A: begin
                    if (bus.run) state_q <= S_IF_B;
                end
                S_IF_B: begin
                    a_q     <= rom_word;
                    state_q <= S_IF_C;
                end
                S_IF_C: begin
                    b_q     <= rom_word;
                    state_q <= S_RD_A;
                end
                S_RD_A: begin
                    c_q     <= rom_word;
                    state_q <= S_RD_B;
                end
                S_RD_B: begin
                    opa_q   <= bus.dmem_rdata;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (neg && (c_q == HALT_ADDR)) begin
                        halt_q  <= 1'b1;
                        state_q <= S_HALT;
                    end else if (neg) begin
                        pc_q    <= c_q;
                        state_q <= S_IF_A;
                    end else begin
                        pc_q    <= pc_q + ADDR_W'(PC_STEP);
                        state_q <= S_IF_A;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IF_A;
                end
            endcase
        end
    end

    // Memory-port outputs decode the state register alone, so they fall to
    // their idle values the moment rst drops -- no partial write can escape.
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bus.rom_addr   = '0;
        bus.dmem_raddr = '0;
        bus.dmem_we    = 1'b0;
        bus.dmem_waddr = '0;
        bus.dmem_wdata = '0;
        unique case (state_q)
            S_IF_A: bus.rom_addr   = pc_q;
            S_IF_B: bus.rom_addr   = pc_q + ADDR_W'(1);
            S_IF_C: bus.rom_addr   = pc_q + ADDR_W'(2);
            S_RD_A: bus.dmem_raddr = a_q;
            S_RD_B: bus.dmem_raddr = b_q;
            S_WB: begin
                bus.dmem_we    = 1'b1;
                bus.dmem_waddr = b_q;
                bus.dmem_wdata = diff;
            end
            default: ;
        endcase
    end

    assign bus.pc   = pc_q;
    assign bus.halt = halt_q;

endmodule : subneg_seq

// File: tb/tb_subneg_seq.sv
// -----------------------------------------------------------------------------
// tb_subneg_seq
// Self-checking bench for subneg_seq. An instruction-level model (ROM and data
// memory arrays, a program counter) predicts each instruction's write and
// branch; the cycle-by-cycle port activity is compared against the six-cycle
// schedule. Directed cases pin the model with hand-computed literals, then a
// randomized program run exercises arbitrary branches, halts and idling.
// -----------------------------------------------------------------------------
module tb_subneg_seq;

    logic clk;
    logic rst;

    subneg_seq_if #(.WIDTH(8), .ADDR_W(8)) bus ();

    subneg_seq #(
        .WIDTH     (8),
        .ADDR_W    (8),
        .RESET_PC  (8'h00),
        .HALT_ADDR (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memories (owned by the stimulus thread) and model state.
    logic [7:0] rom     [256];
    logic [7:0] dmem    [256];
    logic [7:0] ref_mem [256];
    logic [7:0] model_pc;
    bit         model_halt;
    logic [7:0] last_wdata;

    int vectors    = 0;
    int miscompares = 0;

    // Synchronous-read memories: data appears the cycle after the address.
    always @(posedge clk) begin
        bus.rom_data   <= rom[bus.rom_addr];
        bus.dmem_rdata <= dmem[bus.dmem_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle from a falling edge to the next; a write strobe seen
    // now lands in data memory at the rising edge in between.
    task automatic tick();
        if (bus.dmem_we === 1'b1) dmem[bus.dmem_waddr] = bus.dmem_wdata;
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [7:0] pc, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] c);
        rom[pc]           = a;
        rom[8'(pc + 8'd1)] = b;
        rom[8'(pc + 8'd2)] = c;
    endtask

    task automatic set_mem(input logic [7:0] addr, input logic [7:0] val);
        dmem[addr]    = val;
        ref_mem[addr] = val;
    endtask

    task automatic do_reset();
        bus.run = 1'b0;
        rst     = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        model_pc   = 8'h00;
        model_halt = 1'b0;
    endtask

    // Runs one instruction from S_IF_A (called on a falling edge) and checks
    // every cycle against the six-cycle schedule and the ISA-level result.
    task automatic exec_instr(input bit toggle_run);
        logic [7:0] p, a, b, c, r;
        logic [7:0] e_rom, e_rd, e_wa, e_wd;
        logic       e_we;
        bit         neg;
        p = model_pc;
        a = rom[p];
        b = rom[8'(p + 8'd1)];
        c = rom[8'(p + 8'd2)];
        r = 8'(ref_mem[b] - ref_mem[a]);
        ref_mem[b] = r;
        neg = ($signed(r) < 0);
        bus.run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e_rom = 8'h00; e_rd = 8'h00; e_we = 1'b0; e_wa = 8'h00; e_wd = 8'h00;
            case (k)
                0: e_rom = p;
                1: e_rom = 8'(p + 8'd1);
                2: e_rom = 8'(p + 8'd2);
                3: e_rd  = a;
                4: e_rd  = b;
                default: begin e_we = 1'b1; e_wa = b; e_wd = r; end
            endcase
            check("rom_addr",   32'(bus.rom_addr),   32'(e_rom));
            check("dmem_raddr", 32'(bus.dmem_raddr), 32'(e_rd));
            check("dmem_we",    32'(bus.dmem_we),    32'(e_we));
            check("dmem_waddr", 32'(bus.dmem_waddr), 32'(e_wa));
            check("dmem_wdata", 32'(bus.dmem_wdata), 32'(e_wd));
            if (k == 5) last_wdata = bus.dmem_wdata;
            if (toggle_run && k >= 1) bus.run = 1'($urandom_range(0, 1));
            tick();
        end
        if (neg && c == 8'hFF) model_halt = 1'b1;
        else if (neg)          model_pc   = c;
        else                   model_pc   = 8'(p + 8'd3);
        check("pc",   32'(bus.pc),   32'(model_pc));
        check("halt", 32'(bus.halt), 32'(model_halt));
    endtask

    // run low in S_IF_A: the sequencer must sit still, presenting pc only.
    task automatic idle(input int n);
        bus.run = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("idle rom_addr", 32'(bus.rom_addr),   32'(model_pc));
            check("idle raddr",    32'(bus.dmem_raddr), 32'h0);
            check("idle we",       32'(bus.dmem_we),    32'h0);
            check("idle pc",       32'(bus.pc),         32'(model_pc));
            tick();
        end
    endtask

    task automatic halted_idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.run = 1'($urandom_range(0, 1));
            check("halt rom_addr", 32'(bus.rom_addr),   32'h0);
            check("halt raddr",    32'(bus.dmem_raddr), 32'h0);
            check("halt we",       32'(bus.dmem_we),    32'h0);
            check("halt flag",     32'(bus.halt),       32'h1);
            check("halt pc",       32'(bus.pc),         32'(model_pc));
            tick();
        end
    endtask

    // Assert rst asynchronously in the middle of cycle k of an instruction.
    task automatic abort_at(input int k);
        bus.run = 1'b1;
        for (int i = 0; i < k; i++) tick();
        if (k == 5) check("we before abort", 32'(bus.dmem_we), 32'h1);
        #1 rst = 1'b0;
        #1;
        check("abort pc",    32'(bus.pc),         32'h0);
        check("abort halt",  32'(bus.halt),       32'h0);
        check("abort we",    32'(bus.dmem_we),    32'h0);
        check("abort raddr", 32'(bus.dmem_raddr), 32'h0);
        check("abort waddr", 32'(bus.dmem_waddr), 32'h0);
        check("abort wdata", 32'(bus.dmem_wdata), 32'h0);
        tick();
        check("abort no write", 32'(dmem[8'h11]), 32'h5);
        rst = 1'b1;
        check("restart rom_addr", 32'(bus.rom_addr), 32'h0);
        model_pc   = 8'h00;
        model_halt = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        bus.run = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'h00; dmem[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        model_pc = 8'h00; model_halt = 1'b0; last_wdata = 8'h00;

        // Reset values.
        @(negedge clk);
        check("reset pc",       32'(bus.pc),         32'h0);
        check("reset halt",     32'(bus.halt),       32'h0);
        check("reset we",       32'(bus.dmem_we),    32'h0);
        check("reset waddr",    32'(bus.dmem_waddr), 32'h0);
        check("reset wdata",    32'(bus.dmem_wdata), 32'h0);
        check("reset rom_addr", 32'(bus.rom_addr),   32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Mid-instruction reset in S_RD_B, then in S_WB.
        set_instr(8'h00, 8'h10, 8'h11, 8'h20);
        set_mem(8'h10, 8'h03); set_mem(8'h11, 8'h05);
        abort_at(4);
        abort_at(5);

        // Not taken: 5 - 3 = 2.
        do_reset();
        exec_instr(1'b0);
        check("nt wdata lit", 32'(last_wdata), 32'h02);
        check("nt pc lit",    32'(bus.pc),     32'h03);

        // Taken: 3 - 5 = -2.
        do_reset();
        set_mem(8'h10, 8'h05); set_mem(8'h11, 8'h03);
        exec_instr(1'b0);
        check("tk wdata lit", 32'(last_wdata), 32'hFE);
        check("tk pc lit",    32'(bus.pc),     32'h20);

        // Equal operands at distinct addresses.
        do_reset();
        set_mem(8'h10, 8'h04); set_mem(8'h11, 8'h04);
        exec_instr(1'b1);
        check("eq wdata lit", 32'(last_wdata), 32'h00);
        check("eq pc lit",    32'(bus.pc),     32'h03);

        // A == B: result zero, not taken.
        do_reset();
        set_instr(8'h00, 8'h12, 8'h12, 8'h20);
        set_mem(8'h12, 8'h09);
        exec_instr(1'b1);
        check("aeqb wdata lit", 32'(last_wdata), 32'h00);
        check("aeqb pc lit",    32'(bus.pc),     32'h03);

        // Signed overflow: 0x80 - 0x01 = 0x7F, positive, not taken.
        do_reset();
        set_instr(8'h00, 8'h10, 8'h11, 8'h20);
        set_mem(8'h10, 8'h01); set_mem(8'h11, 8'h80);
        exec_instr(1'b1);
        check("ovf wdata lit", 32'(last_wdata), 32'h7F);
        check("ovf pc lit",    32'(bus.pc),     32'h03);

        // Wrap: branch to 0xFE, fetch across 0xFF -> 0x00, fall through to 0x01.
        do_reset();
        set_instr(8'h00, 8'h10, 8'h11, 8'hFE);
        set_mem(8'h10, 8'h05); set_mem(8'h11, 8'h03);
        exec_instr(1'b0);
        check("wrap branch lit", 32'(bus.pc), 32'hFE);
        rom[8'hFE] = 8'h20; rom[8'hFF] = 8'h21;
        set_mem(8'h20, 8'h01); set_mem(8'h21, 8'h01);
        exec_instr(1'b1);
        check("wrap pc lit", 32'(bus.pc), 32'h01);
        idle(5);

        // Halt: negative result with C = 0xFF writes, then freezes.
        do_reset();
        set_instr(8'h00, 8'h10, 8'h11, 8'hFF);
        set_mem(8'h10, 8'h05); set_mem(8'h11, 8'h03);
        exec_instr(1'b1);
        check("halt wdata lit", 32'(last_wdata),    32'hFE);
        check("halt mem lit",   32'(dmem[8'h11]),   32'hFE);
        check("halt flag lit",  32'(bus.halt),      32'h1);
        check("halt pc lit",    32'(bus.pc),        32'h00);
        halted_idle(20);

        // Randomized programs.
        for (int i = 0; i < 256; i++) begin
            rom[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
            set_mem(8'(i), 8'($urandom));
        end
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (model_halt) begin
                halted_idle(3);
                do_reset();
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            exec_instr(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_subneg_seq
